// File: rtl/pe_pkg.sv
//------------------------------------------------------------------------------
// Module : pe_pkg
// Brief  : Controller state encoding and PE-row latency shared with the PE row.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pe_pkg;

    localparam int c_PIPE_LAT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_RELOAD = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pe_row_ctrl_tag_pipe.sv
//------------------------------------------------------------------------------
// Module : tag_pipe
// Brief  : Shift register of {valid,last} tags that rides alongside the PE row.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_valid,
    input  logic i_last,
    output logic o_valid,
    output logic o_last,
    output logic o_pending
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_last;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_valid[0] <= 1'b0;
                    r_last[0]  <= 1'b0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_last[0]  <= i_last;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_valid[i] <= 1'b0;
                    r_last[i]  <= 1'b0;
                end else begin
                    r_valid[i] <= r_valid[i-1];
                    r_last[i]  <= r_last[i-1];
                end
            end
        end
    end

    // Pending covers every stage except the output one, so the controller
    // can flag completion in the same cycle the final tag leaves.
    if (DEPTH > 1) begin : g_pend_multi
        assign o_pending = |r_valid[DEPTH-2:0];
    end else begin : g_pend_single
        assign o_pending = 1'b0;
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/pe_row_ctrl.sv
//------------------------------------------------------------------------------
// Module : pe_row_ctrl
// Brief  : Job controller feeding weights and data vectors into one PE row.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pe_row_ctrl
    import pe_pkg::*;
#(
    parameter int DATA_BW        = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int MATRIX_SIZE    = 8,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int PIPE_LAT       = c_PIPE_LAT_DEFAULT,
    parameter int LEN_BW         = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [LEN_BW-1:0]                job_len,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [WEIGHT_BW*MATRIX_SIZE-1:0] w_data,
    input  logic                             d_valid,
    output logic                             d_ready,
    input  logic [DATA_BW*MATRIX_SIZE-1:0]   d_data,
    output logic                             pe_weight_reload,
    output logic [WEIGHT_BW*MATRIX_SIZE-1:0] pe_weights,
    output logic [DATA_BW*MATRIX_SIZE-1:0]   pe_data_in,
    input  logic [PARTIAL_SUM_BW-1:0]        pe_data_out,
    output logic                             out_valid,
    output logic                             out_last,
    output logic [PARTIAL_SUM_BW-1:0]        out_data,
    output logic                             busy,
    output logic                             done
);

    state_t            r_state;
    logic [LEN_BW-1:0] r_len;
    logic [LEN_BW-1:0] r_cnt;

    logic              w_w_hs;
    logic              w_d_hs;
    logic [LEN_BW-1:0] w_cnt_nxt;
    logic              w_final;
    logic              w_pending;

    assign w_w_hs    = w_valid & w_ready;
    assign w_d_hs    = d_valid & d_ready;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_final   = w_d_hs & (w_cnt_nxt == r_len);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state          <= ST_IDLE;
            r_len            <= '0;
            r_cnt            <= '0;
            pe_weights       <= '0;
            pe_data_in       <= '0;
            pe_weight_reload <= 1'b0;
            w_ready          <= 1'b0;
            d_ready          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done             <= 1'b0;
            pe_weight_reload <= 1'b0;
            pe_data_in       <= w_d_hs ? d_data : '0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (job_len != '0) begin
                            r_len   <= job_len;
                            r_cnt   <= '0;
                            w_ready <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= ST_LOAD_W;
                        end else begin
                            done    <= 1'b1;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_w_hs) begin
                        pe_weights       <= w_data;
                        w_ready          <= 1'b0;
                        pe_weight_reload <= 1'b1;
                        r_state          <= ST_RELOAD;
                    end
                end
                ST_RELOAD: begin
                    d_ready <= 1'b1;
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (w_d_hs) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_final) begin
                            d_ready <= 1'b0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_pending) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    w_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One stage for the pe_data_in register plus the PE row's own latency.
    tag_pipe #(
        .DEPTH (1 + PIPE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .i_valid   (w_d_hs),
        .i_last    (w_final),
        .o_valid   (out_valid),
        .o_last    (out_last),
        .o_pending (w_pending)
    );

    assign out_data = pe_data_out;

endmodule

`default_nettype wire

// File: tb/tb_pe_row_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_pe_row_ctrl
// Brief  : Directed scoreboard bench for pe_row_ctrl with a 2-cycle PE row model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_row_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [7:0]  job_len;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_data;
    logic        d_valid;
    logic        d_ready;
    logic [63:0] d_data;
    logic        pe_weight_reload;
    logic [63:0] pe_weights;
    logic [63:0] pe_data_in;
    logic [19:0] pe_data_out;
    logic        out_valid;
    logic        out_last;
    logic [19:0] out_data;
    logic        busy;
    logic        done;

    pe_row_ctrl dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .job_len          (job_len),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_data           (w_data),
        .d_valid          (d_valid),
        .d_ready          (d_ready),
        .d_data           (d_data),
        .pe_weight_reload (pe_weight_reload),
        .pe_weights       (pe_weights),
        .pe_data_in       (pe_data_in),
        .pe_data_out      (pe_data_out),
        .out_valid        (out_valid),
        .out_last         (out_last),
        .out_data         (out_data),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PE row model: dot product registered twice.
    function automatic logic [19:0] dot(input logic [63:0] d, input logic [63:0] w);
        int acc = 0;
        for (int i = 0; i < 8; i++)
            acc += int'($signed(d[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
        return acc[19:0];
    endfunction

    logic [19:0] r_pe_s1, r_pe_s2;
    always @(posedge clk) begin
        r_pe_s1 <= dot(pe_data_in, pe_weights);
        r_pe_s2 <= r_pe_s1;
    end
    assign pe_data_out = r_pe_s2;

    typedef struct {
        logic [19:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   last_cyc = -100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every presented result.
    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_data), 64'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("out_data",  64'(out_data), 64'(e.data));
                check("out_last",  64'(out_last), 64'(e.last));
                check("out_cycle", 64'(cyc),      64'(e.cyc));
                if (out_last) last_cyc = cyc;
            end
        end
    end

    task automatic start_job(input logic [7:0] len);
        @(negedge clk);
        start   = 1'b1;
        job_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic load_w(input logic [63:0] w);
        int n = 0;
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = w;
        while (!w_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w_ready_seen", 64'(w_ready), 64'd1);
        @(negedge clk);
        w_valid = 1'b0;
        check("reload_pulse", 64'(pe_weight_reload), 64'd1);
        check("pe_weights", pe_weights, w);
        @(negedge clk);
        check("reload_one_cycle", 64'(pe_weight_reload), 64'd0);
    endtask

    task automatic drive_d(input logic vld, input logic [63:0] dat, input logic [19:0] exp,
                           input logic lst, input logic chk_zero, input logic strt);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        if (chk_zero) check("pe_data_in_gap_zero", pe_data_in, 64'd0);
        start   = strt;
        job_len = strt ? 8'd9 : job_len;
        d_valid = vld;
        d_data  = dat;
        if (vld) begin
            while (!d_ready && n < 20) begin
                @(negedge clk);
                start = 1'b0;
                n++;
            end
            if (!d_ready) begin
                check("d_ready_timeout", 64'd0, 64'd1);
            end else begin
                e.data = exp;
                e.last = lst;
                e.cyc  = cyc + 3;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        d_valid = 1'b0;
        start   = 1'b0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("done_after_last", 64'(cyc), 64'(last_cyc + 1));
            check("busy_at_done", 64'(busy), 64'd0);
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int bad;
        rstn = 1'b0; start = 1'b0; job_len = '0;
        w_valid = 1'b0; w_data = '0; d_valid = 1'b0; d_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_ready",   64'({w_ready, d_ready}), 64'd0);
        check("rst_out",     64'({out_valid, out_last, done, pe_weight_reload}), 64'd0);
        check("rst_pe_bus",  pe_weights | pe_data_in, 64'd0);
        rstn = 1'b1;

        // Job of 4, unit weights, element value k on vector k.
        start_job(8'd4);
        check("busy_in_job", 64'(busy), 64'd1);
        load_w({8{8'd1}});
        drive_d(1'b1, {8{8'd1}}, 20'd8,  1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd2}}, 20'd16, 1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd3}}, 20'd24, 1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd4}}, 20'd32, 1'b1, 1'b0, 1'b0);
        wait_done();

        // Job of 3 with d_valid 1,0,0,1,1.
        start_job(8'd3);
        load_w({8{8'd1}});
        drive_d(1'b1, {8{8'd2}}, 20'd16, 1'b0, 1'b0, 1'b0);
        drive_d(1'b0, '0,        20'd0,  1'b0, 1'b0, 1'b0);
        drive_d(1'b0, '0,        20'd0,  1'b0, 1'b1, 1'b0);
        drive_d(1'b1, {8{8'd3}}, 20'd24, 1'b0, 1'b1, 1'b0);
        drive_d(1'b1, {8{8'd5}}, 20'd40, 1'b1, 1'b0, 1'b0);
        wait_done();

        // Zero-length job.
        @(negedge clk);
        start = 1'b1; job_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("zero_len_done",   64'(done), 64'd1);
        check("zero_len_busy",   64'(busy | w_ready), 64'd0);
        @(negedge clk);
        check("zero_len_done_once", 64'(done), 64'd0);
        check("zero_len_no_reload", 64'(pe_weight_reload | busy), 64'd0);

        // Job of 5 with a start pulse in the middle of streaming.
        start_job(8'd5);
        load_w({8{8'd2}});
        drive_d(1'b1, {8{8'd1}}, 20'd16, 1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd2}}, 20'd32, 1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd3}}, 20'd48, 1'b0, 1'b0, 1'b1);
        drive_d(1'b1, {8{8'd4}}, 20'd64, 1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd5}}, 20'd80, 1'b1, 1'b0, 1'b0);
        wait_done();
        repeat (4) @(negedge clk);
        check("start_ignored_idle", 64'({busy, w_ready}), 64'd0);

        // Reset after 2 of 6 vectors.
        start_job(8'd6);
        load_w({8{8'd1}});
        drive_d(1'b1, {8{8'd1}}, 20'd8,  1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd2}}, 20'd16, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn    = 1'b0;
        d_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        check("abort_ctrl", 64'({busy, done, w_ready, d_ready, pe_weight_reload}), 64'd0);
        check("abort_out",  64'({out_valid, out_last}), 64'd0);
        check("abort_bus",  pe_weights | pe_data_in, 64'd0);
        #1 dc = done_cnt;
        repeat (6) @(negedge clk);
        #1 check("abort_no_done", 64'(done_cnt), 64'(dc));
        start_job(8'd2);
        load_w({8{8'd1}});
        drive_d(1'b1, {8{8'd7}}, 20'd56, 1'b0, 1'b0, 1'b0);
        drive_d(1'b1, {8{8'd9}}, 20'd72, 1'b1, 1'b0, 1'b0);
        wait_done();

        // Weight vector withheld for 10 cycles.
        start_job(8'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pe_weight_reload || d_ready || !w_ready || !busy) bad++;
        end
        check("w_stall_outputs", 64'(bad), 64'd0);
        load_w({8{8'd3}});
        drive_d(1'b1, {8{8'd2}}, 20'd48, 1'b1, 1'b0, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
